// File: rtl/spram_line_arbiter.sv
// Single-port frame SPRAM owner: arbitrates queued pixel writes against display line fetches.
// Line reads always win; a starved, full write FIFO is granted one slot after STARVE_MAX reads.
module spram_line_arbiter #(
    parameter int W           = 50,
    parameter int H           = 40,
    parameter int AW          = 15,
    parameter int DW          = 12,
    parameter int WFIFO_DEPTH = 4,
    parameter int STARVE_MAX  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_err,
    output logic [2:0]    fifo_level,
    input  logic          line_req,
    input  logic [7:0]    line_row,
    output logic          line_busy,
    output logic          line_done,
    output logic          line_overrun,
    output logic          pix_valid,
    output logic [7:0]    pix_idx,
    output logic [DW-1:0] pix_data,
    output logic [AW-1:0] spram_addr,
    output logic [DW-1:0] spram_wr_data,
    output logic          spram_wre,
    output logic          spram_ce,
    input  logic [DW-1:0] spram_rd_data
);

    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int RW = $clog2(STARVE_MAX + 1);
    localparam logic [AW:0]   FRAME    = (AW+1)'(W * H);
    localparam logic [8:0]    ROWS     = 9'(H);
    localparam logic [AW-1:0] W_AW     = AW'(W);
    localparam logic [7:0]    COL_LAST = 8'(W - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t          state, state_nx;
    logic [AW-1:0]   fifo_addr [WFIFO_DEPTH];
    logic [DW-1:0]   fifo_data [WFIFO_DEPTH];
    logic [PW-1:0]   wptr, rptr;
    logic [LW-1:0]   level;
    logic [AW-1:0]   base;
    logic [7:0]      col;
    logic [RW-1:0]   read_run;
    logic            rd_vld_p0;
    logic [7:0]      rd_col_p0;

    logic            full, empty, addr_ok, push, store, pop, bypass, wr_avail;
    logic            do_rd, do_wr, req_ok, req_bad, row_ok;
    logic [AW-1:0]   row_base, rd_addr, head_addr;
    logic [DW-1:0]   head_data;
    logic [7:0]      rd_col;

    assign full       = (level == LW'(WFIFO_DEPTH));
    assign empty      = (level == '0);
    assign wr_ready   = spram_ce & ~full;
    assign addr_ok    = ({1'b0, wr_addr} < FRAME);
    assign push       = wr_valid & wr_ready & addr_ok;
    assign fifo_level = 3'(level);
    assign row_ok     = ({1'b0, line_row} < ROWS);
    assign row_base   = AW'(line_row) * W_AW;
    assign pix_data   = pix_valid ? spram_rd_data : '0;

    // An empty FIFO lets an arriving write go straight to the SPRAM in the same cycle it is accepted.
    assign wr_avail  = ~empty | push;
    assign head_addr = empty ? wr_addr : fifo_addr[rptr];
    assign head_data = empty ? wr_data : fifo_data[rptr];
    assign bypass    = do_wr & empty;
    assign pop       = do_wr & ~empty;
    assign store     = push & ~bypass;

    always_comb begin
        state_nx = state;
        do_rd    = 1'b0;
        do_wr    = 1'b0;
        req_ok   = 1'b0;
        req_bad  = 1'b0;
        rd_addr  = base + AW'(col);
        rd_col   = col;
        case (state)
            IDLE: begin
                if (line_req && !line_busy && row_ok) begin
                    req_ok   = 1'b1;
                    do_rd    = 1'b1;
                    rd_addr  = row_base;
                    rd_col   = 8'd0;
                    state_nx = (W == 1) ? DRAIN : FETCH;
                end else begin
                    req_bad = line_req & ~line_busy & ~row_ok;
                    do_wr   = wr_avail;
                end
            end
            FETCH: begin
                if (full && read_run == RW'(STARVE_MAX)) begin
                    do_wr = 1'b1;
                end else begin
                    do_rd = 1'b1;
                    if (col == COL_LAST) state_nx = DRAIN;
                end
            end
            DRAIN: begin
                do_wr    = wr_avail;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (store) begin
            fifo_addr[wptr] <= wr_addr;
            fifo_data[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            wptr          <= '0;
            rptr          <= '0;
            level         <= '0;
            base          <= '0;
            col           <= '0;
            read_run      <= '0;
            spram_ce      <= 1'b0;
            spram_wre     <= 1'b0;
            spram_addr    <= '0;
            spram_wr_data <= '0;
            rd_vld_p0     <= 1'b0;
            rd_col_p0     <= '0;
            pix_valid     <= 1'b0;
            pix_idx       <= '0;
            line_done     <= 1'b0;
            line_busy     <= 1'b0;
            line_overrun  <= 1'b0;
            wr_err        <= 1'b0;
        end else begin
            state    <= state_nx;
            spram_ce <= 1'b1;
            if (store) wptr <= wptr + PW'(1);
            if (pop)   rptr <= rptr + PW'(1);
            level <= level + LW'(store) - LW'(pop);

            if (req_ok) begin
                base <= row_base;
                col  <= 8'd1;
            end else if (state == FETCH && do_rd) begin
                col <= col + 8'd1;
            end

            // Starvation counter only runs while the FIFO sits full.
            if (do_wr || !full) read_run <= '0;
            else if (do_rd)     read_run <= read_run + RW'(1);

            // p0: SPRAM command register (address visible to the RAM this cycle)
            spram_wre <= do_wr;
            if (do_wr) begin
                spram_addr    <= head_addr;
                spram_wr_data <= head_data;
            end else if (do_rd) begin
                spram_addr <= rd_addr;
            end
            rd_vld_p0 <= do_rd;
            rd_col_p0 <= rd_col;

            // p1: read data returns from the RAM alongside its column tag
            pix_valid <= rd_vld_p0;
            pix_idx   <= rd_vld_p0 ? rd_col_p0 : 8'd0;
            line_done <= (rd_vld_p0 && rd_col_p0 == COL_LAST) || req_bad;

            if (req_ok)                      line_busy <= 1'b1;
            else if (line_done && pix_valid) line_busy <= 1'b0;

            line_overrun <= line_req & line_busy;
            wr_err       <= wr_valid & wr_ready & ~addr_ok;
        end
    end

    // bypass is folded into store/pop; kept as a named term for readability of the FIFO bookkeeping
    logic unused_ok;
    assign unused_ok = bypass;

endmodule
